// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite frontend and sprite drawer.
package sprite_pkg;

  localparam int unsigned SPR_W      = 16;
  localparam int unsigned H_VISIBLE  = 640;
  localparam int unsigned TRANSP     = 0;
  localparam int unsigned FRAME_BITS = 8;

  // One draw command; also the frontend FIFO entry layout.
  typedef struct packed {
    logic [9:0]            col;
    logic                  flip;
    logic [FRAME_BITS-1:0] frame;
    logic [3:0]            rowoff;
  } draw_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } draw_state_t;

endpackage

// File: rtl/sprite_drawer.sv
// Fetches one 16-pixel sprite row from the pixel ROM and writes the visible,
// non-transparent pixels into the scanline line buffer, optionally mirrored.
module sprite_drawer
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W     = sprite_pkg::SPR_W,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned FRAME_W   = FRAME_BITS,
  parameter int unsigned H_VISIBLE = sprite_pkg::H_VISIBLE,
  parameter int unsigned TRANSP    = sprite_pkg::TRANSP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               draw_req,
  input  logic [9:0]         col_base,
  input  logic               flip,
  input  logic [FRAME_W-1:0] frame_id,
  input  logic [3:0]         row_off,
  output logic               draw_done,
  output logic [FRAME_W+7:0] rom_addr,
  input  logic [PIX_W-1:0]   rom_data,
  output logic               lb_we,
  output logic [9:0]         lb_addr,
  output logic [PIX_W-1:0]   lb_wdata
);

  localparam logic [3:0] PX_LAST = 4'(SPR_W - 1);

  draw_state_t state, state_nxt;
  draw_cmd_t   cmd_q;
  logic [3:0]  px;
  logic        valid_d;
  logic [3:0]  px_d;
  logic        flip_d;
  logic [3:0]  px_off;
  logic [10:0] col_x;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; requests outside IDLE are dropped.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (draw_req) state_nxt = FETCH;
      FETCH:   if (px == PX_LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch and pixel counter for ROM address generation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q <= '0;
      px    <= '0;
    end else if (state == IDLE && draw_req) begin
      cmd_q <= '{col: col_base, flip: flip, frame: frame_id, rowoff: row_off};
      px    <= '0;
    end else if (state == FETCH) begin
      px <= px + 4'd1;
    end
  end

  // Write-side pipeline: tags that travel alongside each ROM return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_d <= 1'b0;
      px_d    <= '0;
      flip_d  <= 1'b0;
    end else begin
      valid_d <= (state == FETCH);
      px_d    <= px;
      flip_d  <= cmd_q.flip;
    end
  end

  // Outputs: ROM address, column computation with 11-bit clip, idle flag.
  // col_base cannot change under an in-flight write because a new command is
  // only latched in the cycle after the final write.
  always_comb begin
    rom_addr  = (state == FETCH) ? {cmd_q.frame, cmd_q.rowoff, px} : '0;
    px_off    = flip_d ? (PX_LAST - px_d) : px_d;
    col_x     = {1'b0, cmd_q.col} + {7'b0, px_off};
    lb_we     = valid_d && (rom_data != PIX_W'(TRANSP)) && (col_x < 11'(H_VISIBLE));
    lb_addr   = col_x[9:0];
    lb_wdata  = rom_data;
    draw_done = (state == IDLE) && !draw_req;
  end

  // Commands arriving while busy are lost; flag the protocol violation.
  a_req_when_idle: assert property (@(posedge clk) disable iff (!reset)
    draw_req |-> state == IDLE)
    else $warning("sprite_drawer: draw_req while busy, command dropped");

endmodule

// File: tb/tb_sprite_drawer.sv
// Directed bench for sprite_drawer with a behavioural synchronous ROM.
module tb_sprite_drawer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        draw_req = 1'b0;
  logic [9:0]  col_base = '0;
  logic        flip = 1'b0;
  logic [7:0]  frame_id = '0;
  logic [3:0]  row_off = '0;
  logic        draw_done;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [7:0]  lb_wdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned rom_mode = 0;

  sprite_drawer #(.SPR_W(16), .PIX_W(8), .FRAME_W(8), .H_VISIBLE(640), .TRANSP(0)) dut (
    .clk(clk), .reset(reset), .draw_req(draw_req), .col_base(col_base),
    .flip(flip), .frame_id(frame_id), .row_off(row_off), .draw_done(draw_done),
    .rom_addr(rom_addr), .rom_data(rom_data), .lb_we(lb_we),
    .lb_addr(lb_addr), .lb_wdata(lb_wdata)
  );

  always #5 clk = ~clk;

  // ROM content depends only on px: mode 0 returns px+1, mode 1 zeroes even px.
  function automatic logic [7:0] rom_val(input logic [3:0] p);
    if (rom_mode == 1 && p[0] == 1'b0) return 8'd0;
    return 8'(p) + 8'd1;
  endfunction

  always @(posedge clk) rom_data <= rom_val(rom_addr[3:0]);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of cycle 18.
  task automatic do_draw(input logic [9:0] col, input logic f, input logic [7:0] fr,
                         input logic [3:0] row, input bit poke10, input int exp_writes);
    int nw = 0;
    logic [3:0] q;
    logic [7:0] d;
    int cx;
    bit we_exp;
    draw_req = 1'b1; col_base = col; flip = f; frame_id = fr; row_off = row;
    #1 check_eq("done_c0", 32'(draw_done), 0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      draw_req = poke10 && (c == 10);
      if (poke10 && c == 10) begin col_base = 10'd0; flip = ~f; end
      #1;
      if (c <= 16) check_eq("rom_addr", 32'(rom_addr), 32'({fr, row, 4'(c - 1)}));
      if (c >= 2 && c <= 17) begin
        q = 4'(c - 2);
        d = rom_val(q);
        cx = int'(col) + (f ? 15 - int'(q) : int'(q));
        we_exp = (d != 0) && (cx < 640);
        check_eq("lb_we", 32'(lb_we), 32'(we_exp));
        if (we_exp && lb_we) begin
          check_eq("lb_addr", 32'(lb_addr), 32'(cx));
          check_eq("lb_wdata", 32'(lb_wdata), 32'(d));
        end
      end else begin
        check_eq("lb_we_idle", 32'(lb_we), 0);
      end
      if (lb_we) nw++;
      check_eq("draw_done", 32'(draw_done), (c == 18) ? 1 : 0);
    end
    check_eq("n_writes", 32'(nw), 32'(exp_writes));
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    #1 check_eq("rst_done", 32'(draw_done), 1);
    check_eq("rst_we", 32'(lb_we), 0);
    check_eq("rst_addr", 32'(rom_addr), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Reset while idle.
    reset = 1'b0;
    #1 check_eq("idle_rst_done", 32'(draw_done), 1);
    check_eq("idle_rst_we", 32'(lb_we), 0);
    check_eq("idle_rst_addr", 32'(rom_addr), 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    // Plain draw, then flipped draw back-to-back in cycle 18.
    rom_mode = 0;
    do_draw(10'd100, 1'b0, 8'd3, 4'd5, 1'b0, 16);
    do_draw(10'd200, 1'b1, 8'd3, 4'd5, 1'b0, 16);

    // Transparency, with an illegal request in cycle 10 that must be ignored.
    rom_mode = 1;
    do_draw(10'd300, 1'b0, 8'h7a, 4'd2, 1'b1, 8);
    rom_mode = 0;

    // Right clipping.
    do_draw(10'd630, 1'b0, 8'd1, 4'd0, 1'b0, 10);
    do_draw(10'd1020, 1'b1, 8'd1, 4'd15, 1'b0, 0);

    // Reset in cycle 8 of a draw.
    draw_req = 1'b1; col_base = 10'd400; flip = 1'b0; frame_id = 8'd9; row_off = 4'd1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      draw_req = 1'b0;
    end
    reset = 1'b0;
    #1 check_eq("mid_rst_we", 32'(lb_we), 0);
    check_eq("mid_rst_done", 32'(draw_done), 1);
    check_eq("mid_rst_addr", 32'(rom_addr), 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    do_draw(10'd50, 1'b0, 8'd4, 4'd6, 1'b0, 16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_drawer.md
# sprite_drawer

Downstream consumer of the sprite frontend's draw commands. For each accepted command it fetches one 16-pixel row of a sprite frame from the external sprite pixel ROM. It writes the non-transparent, on-screen pixels into the scanline line buffer, optionally mirrored horizontally. It reports idle/busy to the frontend on `draw_done`, which the frontend uses both to pace dequeues and to detect end-of-row.

## Interface
- `SPR_W`, 16: sprite width in pixels; fixed at 16 (row_off and pixel index are 4 bits).
- `PIX_W`, 8: palette-index width of a pixel.
- `FRAME_W`, 8: frame_id width.
- `H_VISIBLE`, 640: visible columns; writes at column >= H_VISIBLE are suppressed.
- `TRANSP`, 0: palette index treated as transparent (never written).

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: asynchronous, active-low.
- `draw_req`  in  1: one-cycle command strobe from the frontend.
- `col_base`  in  10: screen column of sprite pixel 0.
- `flip`  in  1: horizontal mirror.
- `frame_id`  in  FRAME_W: sprite frame.
- `row_off`  in  4: row within the sprite.
- `draw_done`  out  1: 1 = idle and able to accept a command; 0 = busy.
- `rom_addr`  out  FRAME_W+8: {frame_id, row_off, px}. Read latency is 1 cycle (synchronous ROM).
- `rom_data`  in  PIX_W: pixel index for the previous cycle's `rom_addr`.
- `lb_we`  out  1: line-buffer write strobe.
- `lb_addr`  out  10: line-buffer column.
- `lb_wdata`  out  PIX_W: palette index to write.

## Operation
- Registered state: `IDLE`, `FETCH`, `DRAIN`.
- In `IDLE` with `draw_req`=1, latch col_base/flip/frame_id/row_off, set px=0, go to `FETCH`.
- `FETCH`: `rom_addr`={frame, row, px}; px increments each cycle. After px=15 is issued, go to `DRAIN`.
- `DRAIN`: one cycle for the last ROM return, then go to `IDLE`.
- Write pipeline: a 1-cycle delayed valid, px, and flip accompany each ROM return.
- Column = {1'b0,col_base} + (flip ? 15-px_d : px_d), computed in 11 bits with no wrap. A column of 1015 or more is never aliased to low addresses.
- `lb_we` = valid_d && rom_data != TRANSP && column < H_VISIBLE. `lb_addr` = column[9:0], `lb_wdata` = rom_data.
- `draw_done` = (state==`IDLE`) && !draw_req, combinational. It drops in the same cycle `draw_req` is seen, so the frontend never observes a stale idle on the cycle after its strobe.
- `draw_req` in `FETCH` or `DRAIN` is ignored. The command is lost; this is a protocol violation and asserted in simulation.
- Overlap: each draw simply overwrites the line buffer. The last command issued on a row wins, and the frontend issues in ascending sprite index.
- Reset (asynchronous, any time): state `IDLE`, px 0, valid_d 0, `lb_we` 0, `draw_done` 1, `rom_addr` 0. A partial row already written stays in the line buffer.

## Timing
- Cycle 0: `draw_req` high. `draw_done` goes low combinationally; the state register moves to `FETCH` at the end of the cycle.
- Cycles 1–16: `rom_addr` px 0..15.
- Cycles 2–17: possible `lb_we` for px 0..15, one per cycle, in px order.
- Cycle 17 is `DRAIN`. `draw_done` is high again from cycle 18.
- Fixed occupancy of 18 cycles per command, independent of transparency and clipping.
- Back-to-back: a new `draw_req` is accepted in cycle 18 at the earliest.

## Structure
- Shared `sprite_pkg`:
  - constants SPR_W, H_VISIBLE, TRANSP;
  - `draw_cmd_t` packed struct {col, flip, frame, rowoff}, also used by the frontend FIFO entry;
  - state enum.
- No sub-module. The ROM and line buffer are external memories.

## Test plan
- **Reset idle:** assert `reset`=0 mid-idle → `draw_done`=1, `lb_we`=0, `rom_addr`=0.
- **Plain draw:** col_base=100, frame=3, row=5, flip=0, ROM returns px+1 → `rom_addr` 0x0350..0x035F in cycles 1–16. Writes (100,1)..(115,16) occur in cycles 2–17, and `draw_done` rises in cycle 18.
- **Flip:** col_base=200, flip=1, same ROM → writes (215,1), (214,2)..(200,16).
- **Transparency and back-to-back:**
  - Even px return 0 → only 8 writes, at odd columns.
  - A second `draw_req` issued in cycle 18 is accepted; one issued in cycle 10 is ignored and flagged.
- **Right clip:**
  - col_base=630 → writes at 630..639 only (10 writes), `draw_done` still rises in cycle 18.
  - col_base=1020 → zero writes.
- **Reset mid-draw:** assert `reset`=0 in cycle 8 → `lb_we`=0 and `draw_done`=1 immediately. After release, a new command draws all 16 pixels correctly.
